lcd_frame_blender: RTL and testbench
====================================

# lcd_frame_blender

Post-processing stage between the minx LCD framebuffer and the video mixer. On every `frame_complete` it streams the 96x64 1bpp framebuffer (8 pages x 96 column bytes) out of the framebuffer RAM read port. It blends each pixel into a per-pixel 8-bit shade buffer to emulate LCD persistence. The video timing logic reads final pixel intensities back by (x, y).

## Interface

Parameters:
- `LCD_XSIZE`, 96: columns per page.
- `LCD_PAGES`, 8: pages of 8 rows each. Pass length `N = LCD_XSIZE*LCD_PAGES` = 768.

Ports:
- `clk` in 1: system clock (`clk_sys` domain). Single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `frame_complete` in 1: one-cycle pulse from minx.
- `blend_mode` in 2: blend mode. 0 = copy, 1 = 1:1 average, 2 = 3:1 persistence, 3 = copy.
- `fb_address` out 10: framebuffer read address, page*96+column.
- `fb_data` in 8: framebuffer byte, valid exactly 1 cycle after `fb_address` (registered RAM). Bit b is row page*8+b.
- `vid_x` in 7: video read column.
- `vid_y` in 6: video read row.
- `vid_shade` out 8: pixel intensity, 0 = off, 255 = fully dark.
- `busy` out 1: clear or blend pass in progress.
- `pass_done` out 1: one-cycle pulse after a blend pass finishes.
- `frames_dropped` out 8: saturating count of lost `frame_complete` pulses.

## Operation

Shade buffer:
- Internal dual-port RAM, N words x 64 bits. Word address matches the fb byte address.
- Lane b (bits 8b+7:8b) holds the shade of row page*8+b.
- Port A: read-modify-write by the pass engine. Port B: video read only.

States: CLEAR, IDLE, RUN, DONE.
- **CLEAR**: entered on reset. Writes 0 to words 0..N-1, one per cycle, then goes to IDLE. Does not pulse `pass_done`.
- **IDLE**: on `frame_complete`, goes to RUN and latches `blend_mode` into `mode_q`. Mode is fixed for the whole pass.
- **RUN**: address counter `a` runs 0..N-1, one per cycle. `fb_address` = a, and shade port A reads word a.
  - One cycle later, `fb_data` and the old shade word are both valid.
  - All 8 lanes are blended combinationally and written to word a at that edge.
  - After the write of word N-1, goes to DONE.
- **DONE**: `pass_done`=1 for one cycle. Next state is RUN if a pass is pending (clear pending, relatch mode), else IDLE.

Pending and drop rules:
- `frame_complete` while in CLEAR, RUN or DONE sets a single pending flag.
- If pending is already set, `frames_dropped` increments instead, saturating at 255.
- A pulse in the same cycle that pending is consumed counts as a new pending request.

Blend per lane, with old shade s and bit p:
- Target `t` = p ? 255 : 0. Intermediates are 10 bits.
- Mode 0/3: new = t.
- Mode 1: new = (s + t + p) >> 1.
- Mode 2: new = (3s + t + 3p) >> 2.
- These rules guarantee convergence to exactly 255 or 0.

Video read:
- Word address = vid_y[5:3]*96 + vid_x.
- Lane select = vid_y[2:0].
- If `vid_x` >= 96, `vid_shade` = 0.
- A port B read of the word being written in the same cycle returns the old value. Tearing is accepted at frame granularity.

## Timing

- Reset values: `fb_address`=0, `vid_shade`=0, `pass_done`=0, `frames_dropped`=0, pending=0, `busy`=1 (CLEAR).
- Reset asserted mid-pass abandons the pass and restarts CLEAR. Shade contents are then all 0 after CLEAR.
- CLEAR: reset low at edge r. Clear writes occur on cycles r+1..r+N. `busy` falls at r+N+1 (IDLE).
- Pass timing, with `frame_complete` sampled high at edge t in IDLE:
  - `busy`=1 from t+1.
  - `fb_address` = 0..N-1 on cycles t+1..t+N.
  - Writes on t+2..t+N+1.
  - DONE (`pass_done`=1, `busy`=0) on cycle t+N+2.
- Back-to-back passes: if pending, the next RUN starts at t+N+3 with `busy` high again. Gap is the one DONE cycle.
- `vid_shade` latency: 2 cycles from `vid_x`/`vid_y`. Stage 1 registers the address and lane; stage 2 is the RAM output plus lane mux, registered.
- Pass throughput: N+2 cycles ≈ 770 clk. This is well inside one LCD frame.

## Test plan

1. **Reset/clear**: pulse `reset`.
   - `busy` high for 768 cycles after release, then low.
   - `vid_shade`=0 for (0,0), (95,63), (50,17).
   - `pass_done` never pulses.
2. **Copy**: mode 0, fb all 0xFF, one `frame_complete` at t.
   - `fb_address` sequence 0..767 starting t+1.
   - `pass_done` at t+770.
   - `vid_shade`=255 at all 6144 pixels.
   - `vid_x`=96 returns 0.
3. **Persistence**: mode 2, fb[0]=0x01, rest 0, four passes.
   - (0,0) shade = 64, 112, 148, 175.
   - (0,1) and (1,0) stay 0.
   - Switching fb[0]=0x00 with mode 1 then yields 87, 43, 21.
4. **Saturation**: mode 2, constant 0xFF.
   - Shade reaches 255 and stays 255.
   - Constant 0x00 from 255 reaches 0 and stays 0; never wraps.
5. **Pending/drop**:
   - Pulses at t+10, t+20 and t+30 during a pass: second pass starts at t+771 and `frames_dropped`=2.
   - Mode changed mid-pass does not affect the current pass.
6. **Reset mid-pass**: assert `reset` at t+400.
   - Pass is abandoned, `pass_done` absent, `busy` stays high through CLEAR.
   - All shades read 0 afterwards.
   - `frames_dropped`=0.

Source files
------------

// File: rtl/lcd_frame_blender.sv
// lcd_frame_blender
//   Streams the 96x64 1bpp LCD framebuffer (8 pages x 96 column bytes) on every
//   frame_complete and blends each pixel into a per-pixel 8-bit shade buffer to
//   emulate LCD persistence. The video side reads shades back by (x, y).
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   frame_complete    one-cycle pulse requesting a blend pass
//   blend_mode[1:0]   0/3 copy, 1 = 1:1 average, 2 = 3:1 persistence
//   fb_address[9:0]   framebuffer read address (page*96 + column)
//   fb_data[7:0]      framebuffer byte, valid one cycle after fb_address
//   vid_x[6:0]        video read column
//   vid_y[5:0]        video read row
//   vid_shade[7:0]    pixel intensity, two cycles after vid_x/vid_y
//   busy              clear or blend pass in progress
//   pass_done         one-cycle pulse at the end of a blend pass
//   frames_dropped    saturating count of lost frame_complete pulses
//
// state  | meaning
// -------+---------------------------------------------------------------
// CLEAR  | zero the shade buffer, one word per cycle, after reset
// IDLE   | wait for a frame_complete (or a pending one)
// RUN    | stream fb bytes, read-modify-write one shade word per cycle
// DONE   | single cycle: pulse pass_done, start next pass if pending

module lcd_frame_blender #(
    parameter int LCD_XSIZE = 96,
    parameter int LCD_PAGES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_complete,
    input  logic [1:0] blend_mode,
    output logic [9:0] fb_address,
    input  logic [7:0] fb_data,
    input  logic [6:0] vid_x,
    input  logic [5:0] vid_y,
    output logic [7:0] vid_shade,
    output logic       busy,
    output logic       pass_done,
    output logic [7:0] frames_dropped
);

    localparam int N  = LCD_XSIZE * LCD_PAGES;
    localparam int AW = 10;
    localparam logic [AW-1:0] LAST_A = AW'(N - 1);
    // RUN keeps a_q at N for one extra cycle to retire the last write.
    localparam logic [AW-1:0] END_A  = AW'(N);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic            wr_v_q, wr_v_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      mode_q, mode_d;
    logic            pending_q, pending_d;
    logic [7:0]      dropped_q, dropped_d;
    logic            start_req;

    logic [63:0]     shade_mem [N];
    logic [63:0]     shade_rd_q;
    logic [63:0]     blend_word;
    logic            porta_we, porta_re;
    logic [AW-1:0]   porta_addr;
    logic [63:0]     porta_wdata;

    logic [AW-1:0]   vid_addr_q, vid_addr_d;
    logic [2:0]      vid_lane_q;
    logic            vid_oob_q, vid_oob_d;
    logic [7:0]      vid_shade_q;

    assign start_req = frame_complete || pending_q;

    // State register plus the pass-engine registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            a_q       <= '0;
            wr_v_q    <= 1'b0;
            wr_addr_q <= '0;
            mode_q    <= '0;
            pending_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            wr_v_q    <= wr_v_d;
            wr_addr_q <= wr_addr_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (a_q == LAST_A) state_d = S_IDLE;
            S_IDLE:  if (start_req) state_d = S_RUN;
            S_RUN:   if (a_q == END_A) state_d = S_DONE;
            S_DONE:  state_d = start_req ? S_RUN : S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // Counter, mode latch and pending/drop bookkeeping.
    always_comb begin
        a_d       = a_q;
        wr_v_d    = 1'b0;
        wr_addr_d = a_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        dropped_d = dropped_q;
        case (state_q)
            S_CLEAR: a_d = (a_q == LAST_A) ? '0 : a_q + AW'(1);
            S_RUN: begin
                if (a_q != END_A) begin
                    a_d    = a_q + AW'(1);
                    wr_v_d = 1'b1;
                end
            end
            default: begin
                a_d = '0;
                if (start_req) begin
                    mode_d    = blend_mode;
                    // A pulse arriving while pending is consumed becomes the new request.
                    pending_d = pending_q && frame_complete;
                end
            end
        endcase
        if ((state_q == S_CLEAR || state_q == S_RUN) && frame_complete) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end
    end

    // Outputs and shade port A control.
    always_comb begin
        busy        = (state_q == S_CLEAR) || (state_q == S_RUN);
        pass_done   = (state_q == S_DONE);
        fb_address  = (state_q == S_RUN && a_q != END_A) ? a_q : '0;
        porta_re    = (state_q == S_RUN && a_q != END_A);
        porta_we    = 1'b0;
        porta_addr  = wr_addr_q;
        porta_wdata = blend_word;
        if (state_q == S_CLEAR) begin
            porta_we    = 1'b1;
            porta_addr  = a_q;
            porta_wdata = '0;
        end else if (state_q == S_RUN) begin
            porta_we    = wr_v_q;
        end
    end

    // Per-lane blend; the +p / +3p terms round toward the target so the
    // shade converges to exactly 0 or 255.
    always_comb begin
        logic [9:0] s, t, n;
        logic       p;
        blend_word = '0;
        for (int b = 0; b < 8; b++) begin
            s = {2'b00, shade_rd_q[8*b +: 8]};
            p = fb_data[b];
            t = p ? 10'd255 : 10'd0;
            case (mode_q)
                2'd1:    n = (s + t + {9'b0, p}) >> 1;
                2'd2:    n = (s + (s << 1) + t + {8'b0, p, p}) >> 2;
                default: n = t;
            endcase
            blend_word[8*b +: 8] = n[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (porta_we) shade_mem[porta_addr] <= porta_wdata;
        if (porta_re) shade_rd_q <= shade_mem[a_q];
    end

    // Video read: stage 1 registers address/lane, stage 2 registers the lane.
    assign vid_oob_d  = (vid_x >= 7'(LCD_XSIZE));
    assign vid_addr_d = vid_oob_d ? '0
                      : AW'(vid_y[5:3]) * AW'(LCD_XSIZE) + AW'(vid_x);

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_addr_q  <= '0;
            vid_lane_q  <= '0;
            vid_oob_q   <= 1'b1;
            vid_shade_q <= '0;
        end else begin
            vid_addr_q  <= vid_addr_d;
            vid_lane_q  <= vid_y[2:0];
            vid_oob_q   <= vid_oob_d;
            vid_shade_q <= vid_oob_q ? 8'd0 : shade_mem[vid_addr_q][{vid_lane_q, 3'b000} +: 8];
        end
    end

    assign vid_shade      = vid_shade_q;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_lcd_frame_blender.sv
// Directed bench for lcd_frame_blender: reset clear, copy, persistence,
// saturation, lane mapping, pending/drop and reset mid-pass.

module tb_lcd_frame_blender;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_complete;
    logic [1:0] blend_mode;
    logic [9:0] fb_address;
    logic [7:0] fb_data;
    logic [6:0] vid_x;
    logic [5:0] vid_y;
    logic [7:0] vid_shade;
    logic       busy;
    logic       pass_done;
    logic [7:0] frames_dropped;

    logic [7:0] fb_mem [768];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Registered framebuffer RAM model.
    always @(posedge clk) fb_data <= fb_mem[fb_address];

    lcd_frame_blender dut (
        .clk            (clk),
        .reset          (reset),
        .frame_complete (frame_complete),
        .blend_mode     (blend_mode),
        .fb_address     (fb_address),
        .fb_data        (fb_data),
        .vid_x          (vid_x),
        .vid_y          (vid_y),
        .vid_shade      (vid_shade),
        .busy           (busy),
        .pass_done      (pass_done),
        .frames_dropped (frames_dropped)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_blend(input int m, input int s, input int p);
        int t;
        t = p ? 255 : 0;
        if (m == 1) return (s + t + p) / 2;
        if (m == 2) return (3 * s + t + 3 * p) / 4;
        return t;
    endfunction

    function automatic int pat_shade(input int x, input int y);
        int a;
        a = (y / 8) * 96 + x;
        return (((a % 256) >> (y % 8)) & 1) ? 255 : 0;
    endfunction

    task automatic rd(input int x, input int y, output int v);
        vid_x = 7'(x);
        vid_y = 6'(y);
        tick;
        tick;
        v = int'(vid_shade);
    endtask

    task automatic fill_fb(input int val);
        for (int i = 0; i < 768; i++) fb_mem[i] = 8'(val);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!pass_done && cyc < 3000) begin
            tick;
            cyc++;
        end
    endtask

    task automatic run_pass(input int m, output int cyc);
        blend_mode     = 2'(m);
        frame_complete = 1'b1;
        tick;
        frame_complete = 1'b0;
        wait_done(cyc);
        tick;
    endtask

    // Counts samples with busy high after reset release; pd counts pass_done seen.
    task automatic clear_count(output int cyc, output int pd);
        cyc = 0;
        pd  = 0;
        while (busy && cyc < 3000) begin
            if (pass_done) pd++;
            cyc++;
            tick;
        end
    endtask

    initial begin
        int v, c, pd, errs, k, m00, m59;
        int pers_exp[4];
        int avg_exp[3];
        int xs[3];
        pers_exp = '{64, 112, 148, 175};
        avg_exp  = '{87, 43, 21};
        xs       = '{0, 37, 95};

        reset          = 1'b1;
        frame_complete = 1'b0;
        blend_mode     = 2'd0;
        vid_x          = '0;
        vid_y          = '0;
        fill_fb(0);
        tick;
        tick;
        tick;

        // 1. reset / clear
        chk("rst_busy", int'(busy), 1);
        chk("rst_fb_address", int'(fb_address), 0);
        chk("rst_vid_shade", int'(vid_shade), 0);
        chk("rst_pass_done", int'(pass_done), 0);
        chk("rst_frames_dropped", int'(frames_dropped), 0);
        reset = 1'b0;
        clear_count(c, pd);
        chk("clear_busy_cycles", c, 768);
        chk("clear_pass_done", pd, 0);
        rd(0, 0, v);   chk("clear_shade_0_0", v, 0);
        rd(95, 63, v); chk("clear_shade_95_63", v, 0);
        rd(50, 17, v); chk("clear_shade_50_17", v, 0);

        // 2. copy, fb all 0xFF
        fill_fb(255);
        blend_mode     = 2'd0;
        frame_complete = 1'b1;
        tick;
        frame_complete = 1'b0;
        chk("copy_busy_start", int'(busy), 1);
        errs = 0;
        for (k = 0; k < 3000; k++) begin
            if (pass_done) break;
            if (k < 768 && int'(fb_address) != k) errs++;
            tick;
        end
        chk("copy_done_latency", k, 769);
        chk("copy_addr_seq_errs", errs, 0);
        chk("copy_busy_at_done", int'(busy), 0);
        tick;
        errs = 0;
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 96; x++) begin
                rd(x, y, v);
                if (v != 255) errs++;
            end
        chk("copy_all_255_errs", errs, 0);
        rd(96, 0, v);   chk("copy_x96_zero", v, 0);
        rd(127, 63, v); chk("copy_x127_zero", v, 0);

        // 6. reset mid-pass, with drops accumulated first
        frame_complete = 1'b1;
        tick;
        frame_complete = 1'b0;
        pd = 0;
        for (k = 0; k < 400; k++) begin
            if (pass_done) pd++;
            if (k == 100) chk("midrst_dropped_before", int'(frames_dropped), 2);
            frame_complete = (k == 9 || k == 19 || k == 29);
            if (k == 399) reset = 1'b1;
            tick;
        end
        reset          = 1'b0;
        frame_complete = 1'b0;
        chk("midrst_dropped_after", int'(frames_dropped), 0);
        clear_count(c, errs);
        chk("midrst_busy_cycles", c, 768);
        chk("midrst_pass_done", pd + errs, 0);
        tick;
        tick;
        chk("midrst_no_pending", int'(busy), 0);
        rd(0, 0, v);   chk("midrst_shade_0_0", v, 0);
        rd(95, 63, v); chk("midrst_shade_95_63", v, 0);
        rd(50, 17, v); chk("midrst_shade_50_17", v, 0);
        rd(20, 5, v);  chk("midrst_shade_20_5", v, 0);

        // 3. persistence, single lit pixel at (0,0)
        fill_fb(0);
        fb_mem[0] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            run_pass(2, c);
            rd(0, 0, v);
            chk($sformatf("persist_%0d", i), v, pers_exp[i]);
        end
        rd(0, 1, v); chk("persist_0_1", v, 0);
        rd(1, 0, v); chk("persist_1_0", v, 0);
        fb_mem[0] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            run_pass(1, c);
            rd(0, 0, v);
            chk($sformatf("average_%0d", i), v, avg_exp[i]);
        end

        // 4. saturation up then down, mode 2
        fill_fb(255);
        m00 = 21;
        m59 = 0;
        for (int i = 0; i < 20; i++) begin
            run_pass(2, c);
            m00 = ref_blend(2, m00, 1);
            m59 = ref_blend(2, m59, 1);
            rd(0, 0, v); chk($sformatf("sat_up_0_0_%0d", i), v, m00);
            rd(5, 9, v); chk($sformatf("sat_up_5_9_%0d", i), v, m59);
        end
        chk("sat_up_final", v, 255);
        fill_fb(0);
        for (int i = 0; i < 19; i++) begin
            run_pass(2, c);
            m59 = ref_blend(2, m59, 0);
            rd(5, 9, v); chk($sformatf("sat_dn_5_9_%0d", i), v, m59);
        end
        chk("sat_dn_final", v, 0);

        // lane mapping with mode 3 copy, fb[a] = a mod 256
        for (int i = 0; i < 768; i++) fb_mem[i] = 8'(i);
        run_pass(3, c);
        errs = 0;
        for (int y = 0; y < 64; y++)
            for (int j = 0; j < 3; j++) begin
                rd(xs[j], y, v);
                if (v != pat_shade(xs[j], y)) errs++;
            end
        chk("lane_map_errs", errs, 0);

        // 5. pending / drop, mode changed mid-pass
        fill_fb(255);
        blend_mode     = 2'd0;
        frame_complete = 1'b1;
        tick;
        frame_complete = 1'b0;
        for (k = 0; k < 3000; k++) begin
            if (pass_done) break;
            frame_complete = (k == 9 || k == 19 || k == 29);
            if (k == 15) blend_mode = 2'd1;
            tick;
        end
        frame_complete = 1'b0;
        chk("pend_first_done", k, 769);
        chk("pend_dropped", int'(frames_dropped), 2);
        vid_x = 7'd94;
        vid_y = 6'd56;
        tick;
        chk("pend_second_busy", int'(busy), 1);
        chk("pend_second_addr0", int'(fb_address), 0);
        tick;
        chk("pend_mode_held", int'(vid_shade), 255);
        wait_done(c);
        chk("pend_second_done", c, 768);
        chk("pend_dropped_end", int'(frames_dropped), 2);
        tick;
        chk("pend_idle_after", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
